// File: rtl/dv_debounce.sv
// ----------------------------------------------------------------------------
// dv_debounce
//   Conditions the raw pushbutton that advances the division controller FSM.
//   The key is brought into the clock domain through a 2-FF synchroniser and
//   its polarity is normalised (key_s = 1 means pressed). An IDLE/ARM/HELD/REL
//   FSM then accepts a press only after DEBOUNCE_CYCLES stable pressed cycles,
//   and a release only after DEBOUNCE_CYCLES stable released cycles. Exactly
//   one single-cycle dv pulse is emitted per accepted press.
//   All logic is clocked on the rising edge, so dv is stable when the
//   downstream controller samples it on the falling edge.
//
// Ports
//   clock    in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-high
//   key_in   in   1  raw asynchronous pushbutton
//   dv       out  1  one-cycle press pulse to the controller
//   pressed  out  1  debounced key level, 1 = held
//   stateLed out  2  present FSM state code (IDLE=0 ARM=1 HELD=2 REL=3)
// ----------------------------------------------------------------------------
module dv_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_in,
    output logic       dv,
    output logic       pressed,
    output logic [1:0] stateLed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } state_t;

    // Raw key level that means "not pressed"; the synchroniser resets to it
    // so that reset can never look like a press.
    localparam logic             KEY_IDLE_LVL = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             key_s;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dv_q;
    logic             dv_d;

    // ------------------------------------------------------------------
    // Input stage: 2-FF synchroniser, then polarity fix.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= KEY_IDLE_LVL;
            sync2_q <= KEY_IDLE_LVL;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = sync2_q ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // FSM state, counter and dv registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dv_q    <= dv_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The counter only ever increments while below
    // CNT_MAX, so it saturates at DEBOUNCE_CYCLES-1 and cannot wrap.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dv_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end

            ARM: begin
                if (!key_s) begin
                    // Glitch shorter than the debounce window: drop it.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    dv_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HELD: begin
                if (!key_s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end
            end

            REL: begin
                if (key_s) begin
                    // Release bounce: back to HELD without a new dv.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                dv_d    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign dv       = dv_q;
    assign pressed  = (state_q == HELD) || (state_q == REL);
    assign stateLed = state_q;

endmodule
